// File: rtl/led_fader.sv
// RGB fader: CPU-programmed targets, each tick steps R/G/B toward target and writes R,G,B to the PWM block 1..3 cycles later.
// No backpressure downstream; ticks arriving mid-sequence are dropped (sticky OVR). LED_FADER_BREATHE_EN adds ping-pong breathing.
module led_fader #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 4,
    parameter int CLK_FREQ     = 12000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    output logic [ADDRESS_BITS-1:0] PWM_ADDRESS,
    output logic [BITS-1:0]         PWM_DATA,
    output logic                    PWM_WR
);

    localparam logic [BITS-1:0] DIV_RST = BITS'(CLK_FREQ / 1000 - 1);

    localparam logic [ADDRESS_BITS-1:0] A_TGT_R  = ADDRESS_BITS'(0);
    localparam logic [ADDRESS_BITS-1:0] A_TGT_G  = ADDRESS_BITS'(1);
    localparam logic [ADDRESS_BITS-1:0] A_TGT_B  = ADDRESS_BITS'(2);
    localparam logic [ADDRESS_BITS-1:0] A_DIV    = ADDRESS_BITS'(3);
    localparam logic [ADDRESS_BITS-1:0] A_STEP   = ADDRESS_BITS'(4);
    localparam logic [ADDRESS_BITS-1:0] A_CTRL   = ADDRESS_BITS'(5);
    localparam logic [ADDRESS_BITS-1:0] A_STATUS = ADDRESS_BITS'(6);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_R  = ADDRESS_BITS'(8);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_G  = ADDRESS_BITS'(9);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_B  = ADDRESS_BITS'(10);

    typedef enum logic [1:0] {IDLE, UPD_R, UPD_G, UPD_B} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BITS-1:0] tgt_q   [3];
    logic [BITS-1:0] cur_q   [3];
    logic [BITS-1:0] eff_tgt [3];
    logic [BITS-1:0] div_q;
    logic [BITS-1:0] step_q;
    logic [BITS-1:0] presc_q;
    logic            en_q;
    logic            ovr_q;
    logic            tick;
    logic [2:0]      done;
    logic [BITS-1:0] cur_sel;
    logic [BITS-1:0] tgt_sel;
    logic [BITS-1:0] ch_new;
    logic [BITS-1:0] ctrl_rd;
    logic [BITS-1:0] status_rd;

    // Move toward target by at most stp; the difference test keeps it from wrapping or overshooting.
    function automatic logic [BITS-1:0] step_toward(input logic [BITS-1:0] cur,
                                                    input logic [BITS-1:0] tgt,
                                                    input logic [BITS-1:0] stp);
        logic [BITS-1:0] res;
        if (tgt >= cur) begin
            res = ((tgt - cur) <= stp) ? tgt : cur + stp;
        end else begin
            res = ((cur - tgt) <= stp) ? tgt : cur - stp;
        end
        return res;
    endfunction

    assign tick = en_q && (presc_q == div_q);

`ifdef LED_FADER_BREATHE_EN
    logic breathe_q;
    logic dir_down_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            breathe_q  <= 1'b0;
            dir_down_q <= 1'b0;
        end else begin
            if (WR && ADDRESS == A_CTRL) begin
                breathe_q <= DATA_IN[1];
            end
            if (en_q && breathe_q && state == IDLE && (&done)) begin
                dir_down_q <= ~dir_down_q;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_tgt[i] = dir_down_q ? '0 : tgt_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eff_tgt[i] = tgt_q[i];
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            done[i] = (cur_q[i] == eff_tgt[i]);
        end
    end

    always_comb begin
        cur_sel = cur_q[0];
        tgt_sel = eff_tgt[0];
        case (state)
            UPD_G: begin
                cur_sel = cur_q[1];
                tgt_sel = eff_tgt[1];
            end
            UPD_B: begin
                cur_sel = cur_q[2];
                tgt_sel = eff_tgt[2];
            end
            default: ;
        endcase
    end

    assign ch_new = step_toward(cur_sel, tgt_sel, step_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        PWM_WR      = 1'b0;
        PWM_ADDRESS = '0;
        PWM_DATA    = '0;
        case (state)
            IDLE: begin
                if (tick) state_nxt = UPD_R;
            end
            UPD_R: begin
                state_nxt   = UPD_G;
                PWM_WR      = 1'b1;
                PWM_ADDRESS = ADDRESS_BITS'(0);
                PWM_DATA    = ch_new;
            end
            UPD_G: begin
                state_nxt   = UPD_B;
                PWM_WR      = 1'b1;
                PWM_ADDRESS = ADDRESS_BITS'(1);
                PWM_DATA    = ch_new;
            end
            UPD_B: begin
                state_nxt   = IDLE;
                PWM_WR      = 1'b1;
                PWM_ADDRESS = ADDRESS_BITS'(2);
                PWM_DATA    = ch_new;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                tgt_q[i] <= '0;
                cur_q[i] <= '0;
            end
            div_q   <= DIV_RST;
            step_q  <= BITS'(1);
            en_q    <= 1'b0;
            ovr_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            if (WR) begin
                case (ADDRESS)
                    A_TGT_R: tgt_q[0] <= DATA_IN;
                    A_TGT_G: tgt_q[1] <= DATA_IN;
                    A_TGT_B: tgt_q[2] <= DATA_IN;
                    A_DIV:   div_q    <= DATA_IN;
                    A_STEP:  step_q   <= DATA_IN;
                    A_CTRL:  en_q     <= DATA_IN[0];
                    default: ;
                endcase
            end

            case (state)
                UPD_R:   cur_q[0] <= ch_new;
                UPD_G:   cur_q[1] <= ch_new;
                UPD_B:   cur_q[2] <= ch_new;
                default: ;
            endcase

            // A CTRL write wins over a same-cycle dropped tick so software always sees the clear.
            if (WR && ADDRESS == A_CTRL) begin
                ovr_q <= 1'b0;
            end else if (tick && state != IDLE) begin
                ovr_q <= 1'b1;
            end

            if (!en_q || tick || (WR && ADDRESS == A_DIV)) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + BITS'(1);
            end
        end
    end

    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[0] = en_q;
        ctrl_rd[4] = ovr_q;
`ifdef LED_FADER_BREATHE_EN
        ctrl_rd[1] = breathe_q;
`endif
        status_rd      = '0;
        status_rd[0]   = (state != IDLE);
        status_rd[3:1] = {done[2], done[1], done[0]};
    end

    always_comb begin
        DATA_OUT = '0;
        case (ADDRESS)
            A_TGT_R:  DATA_OUT = tgt_q[0];
            A_TGT_G:  DATA_OUT = tgt_q[1];
            A_TGT_B:  DATA_OUT = tgt_q[2];
            A_DIV:    DATA_OUT = div_q;
            A_STEP:   DATA_OUT = step_q;
            A_CTRL:   DATA_OUT = ctrl_rd;
            A_STATUS: DATA_OUT = status_rd;
            A_CUR_R:  DATA_OUT = cur_q[0];
            A_CUR_G:  DATA_OUT = cur_q[1];
            A_CUR_B:  DATA_OUT = cur_q[2];
            default:  DATA_OUT = '0;
        endcase
    end

endmodule

// File: tb/tb_led_fader.sv
// Scoreboarded bench for led_fader: expected PWM writes are queued with the stimulus and popped as the DUT emits them.
module tb_led_fader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  ADDRESS;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        WR;
    logic [3:0]  PWM_ADDRESS;
    logic [15:0] PWM_DATA;
    logic        PWM_WR;

    always #5 CLK = ~CLK;

    led_fader #(
        .BITS(16),
        .ADDRESS_BITS(4),
        .CLK_FREQ(12000000)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .ADDRESS(ADDRESS),
        .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT),
        .WR(WR),
        .PWM_ADDRESS(PWM_ADDRESS),
        .PWM_DATA(PWM_DATA),
        .PWM_WR(PWM_WR)
    );

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_on        = 1'b1;
    bit   first_arm    = 1'b0;
    int   first_wr_cyc = -1000;
    int   last_wr_cyc  = 0;
    int   cyc          = 0;
    int   n_cmp        = 0;
    int   n_bad        = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        exp_t e;
        if (PWM_WR === 1'b1) begin
            if (first_arm) begin
                first_wr_cyc = cyc;
                first_arm    = 1'b0;
            end
            if (sb_on) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_pwm_wr", 32'(PWM_WR), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("pwm_addr", 32'(PWM_ADDRESS), 32'(e.addr));
                    check_val("pwm_data", 32'(PWM_DATA), 32'(e.data));
                end
            end
        end
    end

    task automatic push_rgb(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        sb_q.push_back('{addr: 4'd0, data: r});
        sb_q.push_back('{addr: 4'd1, data: g});
        sb_q.push_back('{addr: 4'd2, data: b});
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge CLK);
        ADDRESS     = a;
        DATA_IN     = d;
        WR          = 1'b1;
        last_wr_cyc = cyc;
        @(negedge CLK);
        WR = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
        ADDRESS = a;
        #1;
        d = DATA_OUT;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        cpu_read(a, rd);
        check_val(tag, 32'(rd), 32'(exp));
    endtask

    // Returns at a rising edge so the caller can change sb_on before the monitor's next sample.
    task automatic wait_drain(input string tag, input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(posedge CLK);
            n++;
        end
        check_val(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c_exp [3];
        logic [15:0] bseq  [6];
        int          n_wr;
        int          prev_a;
        bit          found;
        int          wc;

        RST = 1'b1; WR = 1'b0; ADDRESS = '0; DATA_IN = '0;
        repeat (3) @(negedge CLK);

        check_val("rst_pwm_wr", 32'(PWM_WR), 32'd0);
        check_val("rst_pwm_addr", 32'(PWM_ADDRESS), 32'd0);
        check_val("rst_pwm_data", 32'(PWM_DATA), 32'd0);
        read_check("rst_div", 4'd3, 16'd11999);
        read_check("rst_step", 4'd4, 16'd1);
        read_check("rst_ctrl", 4'd5, 16'h0000);
        read_check("rst_status", 4'd6, 16'h000E);
        read_check("rst_cur_r", 4'd8, 16'h0000);
        read_check("rst_unmapped", 4'd7, 16'h0000);
        @(negedge CLK);
        RST = 1'b0;

        // Ramp R to 0x300 in 0x100 steps, DIV=3.
        cpu_write(4'd3, 16'd3);
        cpu_write(4'd4, 16'h0100);
        cpu_write(4'd0, 16'h0300);
        cpu_write(4'd15, 16'hFFFF);
        read_check("unmapped_write_ignored", 4'd15, 16'h0000);
        push_rgb(16'h0100, 16'h0000, 16'h0000);
        push_rgb(16'h0200, 16'h0000, 16'h0000);
        push_rgb(16'h0300, 16'h0000, 16'h0000);
        push_rgb(16'h0300, 16'h0000, 16'h0000);
        first_arm = 1'b1;
        cpu_write(4'd5, 16'h0001);
        wc = last_wr_cyc;
        wait_drain("a_drain", 100);
        sb_on = 1'b0;
        check_val("a_first_latency", 32'(first_wr_cyc - wc), 32'd5);
        cpu_write(4'd5, 16'h0000);
        repeat (8) @(negedge CLK);
        sb_on = 1'b1;
        repeat (20) @(negedge CLK);
        read_check("a_status_idle", 4'd6, 16'h000E);
        read_check("a_cur_r", 4'd8, 16'h0300);

        // G ramps up to 0x50, then down to 0x20 without underflow.
        cpu_write(4'd4, 16'h0040);
        cpu_write(4'd1, 16'h0050);
        push_rgb(16'h0300, 16'h0040, 16'h0000);
        push_rgb(16'h0300, 16'h0050, 16'h0000);
        cpu_write(4'd5, 16'h0001);
        wait_drain("b_up_drain", 100);
        sb_on = 1'b0;
        cpu_write(4'd5, 16'h0000);
        repeat (8) @(negedge CLK);
        read_check("b_cur_g_50", 4'd9, 16'h0050);
        cpu_write(4'd1, 16'h0020);
        read_check("b_status_g_not_done", 4'd6, 16'h000A);
        push_rgb(16'h0300, 16'h0020, 16'h0000);
        sb_on = 1'b1;
        cpu_write(4'd5, 16'h0001);
        wait_drain("b_down_drain", 100);
        sb_on = 1'b0;
        cpu_write(4'd5, 16'h0000);
        repeat (8) @(negedge CLK);
        read_check("b_cur_g_20", 4'd9, 16'h0020);
        read_check("b_status_done", 4'd6, 16'h000E);

        // DIV=0: one triple per 4 cycles, dropped ticks set OVR.
        c_exp[0] = 16'h0300; c_exp[1] = 16'h0020; c_exp[2] = 16'h0000;
        cpu_write(4'd3, 16'd0);
        cpu_write(4'd5, 16'h0001);
        repeat (8) @(negedge CLK);
        n_wr   = 0;
        prev_a = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (PWM_WR === 1'b1) begin
                n_wr++;
                if (PWM_ADDRESS < 4'd3) begin
                    check_val("c_data", 32'(PWM_DATA), 32'(c_exp[PWM_ADDRESS]));
                end else begin
                    check_val("c_addr_range", 32'(PWM_ADDRESS), 32'd0);
                end
                if (prev_a >= 0) check_val("c_addr_order", 32'(PWM_ADDRESS), 32'((prev_a + 1) % 3));
                prev_a = int'(PWM_ADDRESS);
            end
        end
        check_val("c_write_count", 32'(n_wr), 32'd30);
        read_check("c_ovr_set", 4'd5, 16'h0011);
        cpu_write(4'd5, 16'h0001);
        read_check("c_ovr_cleared", 4'd5, 16'h0001);

        // Reset during UPD_G aborts at once.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (PWM_WR === 1'b1 && PWM_ADDRESS == 4'd1) found = 1'b1;
        end
        check_val("d_found_upd_g", 32'(found), 32'd1);
        #1 RST = 1'b1;
        #1;
        check_val("d_rst_pwm_wr", 32'(PWM_WR), 32'd0);
        check_val("d_rst_pwm_addr", 32'(PWM_ADDRESS), 32'd0);
        read_check("d_cur_r", 4'd8, 16'h0000);
        read_check("d_cur_g", 4'd9, 16'h0000);
        read_check("d_cur_b", 4'd10, 16'h0000);
        read_check("d_div", 4'd3, 16'd11999);
        read_check("d_ctrl", 4'd5, 16'h0000);
        sb_q.delete();
        sb_on = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);

        // Breathing (or plain ramp without the macro) on B.
`ifdef LED_FADER_BREATHE_EN
        bseq[0] = 16'd2; bseq[1] = 16'd4; bseq[2] = 16'd2;
        bseq[3] = 16'd0; bseq[4] = 16'd2; bseq[5] = 16'd4;
`else
        bseq[0] = 16'd2; bseq[1] = 16'd4; bseq[2] = 16'd4;
        bseq[3] = 16'd4; bseq[4] = 16'd4; bseq[5] = 16'd4;
`endif
        cpu_write(4'd2, 16'd4);
        cpu_write(4'd4, 16'd2);
        cpu_write(4'd3, 16'd0);
        for (int i = 0; i < 6; i++) push_rgb(16'h0000, 16'h0000, bseq[i]);
        cpu_write(4'd5, 16'h0003);
        wait_drain("e_drain", 100);
        sb_on = 1'b0;
`ifdef LED_FADER_BREATHE_EN
        read_check("e_ctrl", 4'd5, 16'h0013);
`else
        read_check("e_ctrl", 4'd5, 16'h0011);
`endif
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
